// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: handshaked request/response driver for the logical/shift ALU.
// Define ALU_OPCHK_EN to flag opcodes 011/111 with rsp_err instead of forwarding them.
module alu_op_sequencer #(
    parameter int WIDTH      = 32,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic             alu_sel0,
    output logic             alu_sel1,
    output logic             alu_sel2,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_op,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic accept, bad_op;
    assign req_ready = (state == IDLE) && !reset;
    assign accept = req_valid && req_ready;
`ifdef ALU_OPCHK_EN
    assign bad_op = req_op[1:0] == 2'b11;
`else
    assign bad_op = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (bad_op ? RESP : DRIVE) : IDLE;
            DRIVE:   state_nx = (cnt == 4'd0) ? CAPTURE : DRIVE;
            CAPTURE: state_nx = RESP;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    // ALU lines are only written at a normal accept, so they hold through RESP and IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_sel0  <= 1'b0;
            alu_sel1  <= 1'b0;
            alu_sel2  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_op    <= '0;
            rsp_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            state <= state_nx;
            if (accept && !bad_op) begin
                alu_in1 <= req_a;
                alu_in2 <= req_b;
                {alu_sel2, alu_sel1, alu_sel0} <= req_op;
                cnt <= 4'(SETTLE_CYC - 1);
            end
            if (accept && bad_op) begin
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_op    <= req_op;
                rsp_err   <= 1'b1;
            end
            if (state == DRIVE && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == CAPTURE) begin
                rsp_valid <= 1'b1;
                rsp_data  <= alu_out;
                rsp_op    <= {alu_sel2, alu_sel1, alu_sel0};
                rsp_err   <= 1'b0;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                op_count  <= op_count + CNT_W'(1);
            end
        end
    end
endmodule
